// File: rtl/clahe_frame_seq_if.sv
// clahe_frame_seq_if: video input, frame configuration and sequencer status bundle
interface clahe_frame_seq_if #(parameter int DIM_W = 11, parameter int TH_W = 16);
  logic in_v_sync, in_data_en, clahe_en, clip_done;
  logic [DIM_W-1:0] width_in, height_in, cfg_width, cfg_height;
  logic [TH_W-1:0] contrast_th_in, cfg_contrast_th;
  logic [2*DIM_W-1:0] block_size, in_cnt;
  logic active, frame_start, bank_sel, in_done, o_data_en, out_done;
  logic err_overrun, err_short, err_no_swap, err_cfg;
  modport master (
    output in_v_sync, in_data_en, clahe_en, clip_done, width_in, height_in, contrast_th_in,
    input cfg_width, cfg_height, cfg_contrast_th, block_size, in_cnt, active, frame_start,
    input bank_sel, in_done, o_data_en, out_done, err_overrun, err_short, err_no_swap, err_cfg
  );
  modport slave (
    input in_v_sync, in_data_en, clahe_en, clip_done, width_in, height_in, contrast_th_in,
    output cfg_width, cfg_height, cfg_contrast_th, block_size, in_cnt, active, frame_start,
    output bank_sel, in_done, o_data_en, out_done, err_overrun, err_short, err_no_swap, err_cfg
  );
endinterface

// File: rtl/clahe_frame_seq.sv
// clahe_frame_seq: CLAHE frame start detect, config freeze, pixel counting, output enable and bank control
module clahe_frame_seq #(
  parameter int DW = 8,
  parameter int DIM_W = 11,
  parameter int TH_W = 16,
  parameter int TILES_LOG2 = 4,
  parameter int PIPE_LAT = 6
) (
  input logic clk,
  input logic rst,
  clahe_frame_seq_if.slave bus
);
  localparam int CW = 2 * DIM_W;
  if (DW < 1 || PIPE_LAT < 1) begin : g_bad_param
    $error("clahe_frame_seq: DW and PIPE_LAT must be >= 1");
  end
  logic rise, fall, cnt_en, room, odv;
  logic [CW-1:0] prod;
  logic vs_q, vs_d, fs_q, fs_d, act_q, act_d, actp_q, actp_d, bank_q, bank_d, swp_q, swp_d;
  logic idone_q, idone_d, e_ov_q, e_ov_d, e_sh_q, e_sh_d, e_ns_q, e_ns_d, e_cfg_q, e_cfg_d;
  logic [DIM_W-1:0] cw_q, cw_d, ch_q, ch_d;
  logic [TH_W-1:0] cth_q, cth_d;
  logic [CW-1:0] tot_q, tot_d, bs_q, bs_d, icnt_q, icnt_d, ocnt_q, ocnt_d;
  logic [PIPE_LAT-1:0] sr_q, sr_d;
  always_comb begin
    rise = bus.in_v_sync && !vs_q;
    fall = !bus.in_v_sync && vs_q;
    prod = CW'(bus.width_in) * CW'(bus.height_in);
    cnt_en = bus.in_v_sync && bus.in_data_en && act_q;
    room = icnt_q != tot_q;
    odv = sr_q[PIPE_LAT-1] && act_q && ocnt_q != tot_q;
    vs_d = bus.in_v_sync;
    fs_d = rise;
    act_d = rise ? (bus.clahe_en && prod != '0) : act_q;
    actp_d = rise ? act_q : actp_q;
    cw_d = rise ? bus.width_in : cw_q;
    ch_d = rise ? bus.height_in : ch_q;
    cth_d = rise ? bus.contrast_th_in : cth_q;
    tot_d = rise ? prod : tot_q;
    bs_d = fs_q ? tot_q >> TILES_LOG2 : bs_q;
    bank_d = bank_q ^ bus.clip_done;
    swp_d = !fs_q && (swp_q || bus.clip_done);
    icnt_d = rise ? '0 : icnt_q + CW'(cnt_en && room);
    idone_d = !rise && cnt_en && room && (icnt_q + CW'(1) == tot_q);
    ocnt_d = rise ? '0 : ocnt_q + CW'(odv);
    sr_d = PIPE_LAT'({sr_q, bus.in_data_en});
    e_ov_d = !rise && (e_ov_q || (cnt_en && !room));
    e_sh_d = !rise && (e_sh_q || (fall && act_q && room));
    e_ns_d = e_ns_q || (fs_q && actp_q && !swp_q && !bus.clip_done);
    e_cfg_d = e_cfg_q || (rise && bus.clahe_en && prod == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b1;
      {fs_q, act_q, actp_q, bank_q, swp_q, idone_q, e_ov_q, e_sh_q, e_ns_q, e_cfg_q} <= '0;
      {cw_q, ch_q, cth_q, tot_q, bs_q, icnt_q, ocnt_q, sr_q} <= '0;
    end else begin
      {vs_q, fs_q, act_q, actp_q, bank_q, swp_q} <= {vs_d, fs_d, act_d, actp_d, bank_d, swp_d};
      {idone_q, e_ov_q, e_sh_q, e_ns_q, e_cfg_q} <= {idone_d, e_ov_d, e_sh_d, e_ns_d, e_cfg_d};
      {cw_q, ch_q, cth_q, tot_q, bs_q} <= {cw_d, ch_d, cth_d, tot_d, bs_d};
      {icnt_q, ocnt_q, sr_q} <= {icnt_d, ocnt_d, sr_d};
    end
  end
  assign bus.active = act_q;
  assign bus.frame_start = fs_q;
  assign bus.cfg_width = cw_q;
  assign bus.cfg_height = ch_q;
  assign bus.cfg_contrast_th = cth_q;
  assign bus.block_size = bs_q;
  assign bus.bank_sel = bank_q;
  assign bus.in_cnt = icnt_q;
  assign bus.in_done = idone_q;
  assign bus.o_data_en = odv;
  assign bus.out_done = odv && (ocnt_q + CW'(1) == tot_q);
  assign bus.err_overrun = e_ov_q;
  assign bus.err_short = e_sh_q;
  assign bus.err_no_swap = e_ns_q;
  assign bus.err_cfg = e_cfg_q;
endmodule

// File: tb/tb_clahe_frame_seq.sv
// tb_clahe_frame_seq: directed checks of frame sequencing, counting, output enable and error flags
module tb_clahe_frame_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int n_o, n_od, n_id, first_o, od_at;
  clahe_frame_seq_if #(.DIM_W(11), .TH_W(16)) bus ();
  clahe_frame_seq #(.DW(8), .DIM_W(11), .TH_W(16), .TILES_LOG2(2), .PIPE_LAT(6)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic start(input int w, input int h, input logic en);
    bus.width_in = 11'(w);
    bus.height_in = 11'(h);
    bus.clahe_en = en;
    bus.in_v_sync = 1'b1;
    tick();
  endtask
  task automatic stop();
    bus.in_v_sync = 1'b0;
    bus.in_data_en = 1'b0;
    tick();
  endtask
  task automatic clip();
    bus.clip_done = 1'b1;
    tick();
    bus.clip_done = 1'b0;
  endtask
  task automatic run(input int npix, input int ncyc, input int en_off);
    n_o = 0; n_od = 0; n_id = 0; first_o = -1; od_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (bus.o_data_en) begin
        n_o++;
        if (first_o < 0) first_o = c;
      end
      if (bus.out_done) begin
        n_od++;
        od_at = n_o;
      end
      if (bus.in_done) n_id++;
      if (c == en_off) bus.clahe_en = 1'b0;
      bus.in_data_en = c < npix;
      tick();
    end
    bus.in_data_en = 1'b0;
  endtask
  initial begin
    bus.in_v_sync = 0; bus.in_data_en = 0; bus.clahe_en = 0; bus.clip_done = 0;
    bus.width_in = 0; bus.height_in = 0; bus.contrast_th_in = 16'h1234;
    tick(); tick();
    chk("rst_active", bus.active, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_bank", bus.bank_sel, 0);
    chk("rst_incnt", bus.in_cnt, 0);
    chk("rst_oen", bus.o_data_en, 0);
    chk("rst_bsize", bus.block_size, 0);
    chk("rst_errs", {bus.err_overrun, bus.err_short, bus.err_no_swap, bus.err_cfg}, 0);
    rst = 1'b0;
    tick();
    start(8, 4, 1);
    chk("a_fs", bus.frame_start, 1);
    chk("a_active", bus.active, 1);
    chk("a_cfg_w", bus.cfg_width, 8);
    chk("a_cfg_h", bus.cfg_height, 4);
    chk("a_cfg_th", bus.cfg_contrast_th, 32'h1234);
    chk("a_bsize_fs", bus.block_size, 0);
    run(32, 45, -1);
    chk("a_fs_after", bus.frame_start, 0);
    chk("a_bsize", bus.block_size, 8);
    chk("a_incnt", bus.in_cnt, 32);
    chk("a_in_done", n_id, 1);
    chk("a_n_oen", n_o, 32);
    chk("a_first_oen", first_o, 6);
    chk("a_n_odone", n_od, 1);
    chk("a_odone_at", od_at, 32);
    stop();
    chk("a_err_short", bus.err_short, 0);
    clip();
    chk("a_bank", bus.bank_sel, 1);
    start(8, 4, 1);
    run(32, 45, 10);
    chk("b_active_hold", bus.active, 1);
    chk("b_n_oen", n_o, 32);
    chk("b_n_odone", n_od, 1);
    chk("b_no_swap", bus.err_no_swap, 0);
    stop();
    clip();
    chk("b_bank", bus.bank_sel, 0);
    start(8, 4, 0);
    chk("c_active", bus.active, 0);
    run(32, 45, -1);
    chk("c_n_oen", n_o, 0);
    chk("c_in_done", n_id, 0);
    chk("c_n_odone", n_od, 0);
    chk("c_incnt", bus.in_cnt, 0);
    stop();
    start(8, 4, 1);
    run(34, 45, -1);
    chk("d_incnt_sat", bus.in_cnt, 32);
    chk("d_overrun", bus.err_overrun, 1);
    chk("d_n_oen", n_o, 32);
    chk("d_in_done", n_id, 1);
    chk("d_n_odone", n_od, 1);
    stop();
    start(8, 4, 1);
    chk("e_ovr_clear", bus.err_overrun, 0);
    bus.clip_done = 1'b1;
    tick();
    bus.clip_done = 1'b0;
    chk("e_bank_coinc", bus.bank_sel, 1);
    chk("e_no_swap_coinc", bus.err_no_swap, 0);
    run(20, 20, -1);
    chk("e_incnt", bus.in_cnt, 20);
    stop();
    chk("e_err_short", bus.err_short, 1);
    start(8, 4, 1);
    chk("f_short_clear", bus.err_short, 0);
    tick();
    chk("f_no_swap", bus.err_no_swap, 1);
    stop();
    start(0, 4, 1);
    chk("g_active", bus.active, 0);
    chk("g_err_cfg", bus.err_cfg, 1);
    bus.in_data_en = 1'b1;
    rst = 1'b1;
    tick();
    chk("r_errs", {bus.err_overrun, bus.err_short, bus.err_no_swap, bus.err_cfg}, 0);
    chk("r_state", {bus.active, bus.frame_start, bus.bank_sel, bus.o_data_en, bus.out_done, bus.in_done}, 0);
    chk("r_cnts", {bus.in_cnt, bus.cfg_width}, 0);
    chk("r_bsize", bus.block_size, 0);
    rst = 1'b0;
    bus.in_data_en = 1'b0;
    bus.width_in = 8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_no_fs_high", bus.frame_start, 0);
    end
    stop();
    start(8, 4, 1);
    chk("h_fs", bus.frame_start, 1);
    chk("h_active", bus.active, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
